multi_cycle_control: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback over
//  one shared ALU and one shared memory port. Drives aluop[1:0] into alu_control and all datapath mux/enable

---
 rtl/multi_cycle_control_pkg.sv | 58 +++++
 rtl/multi_cycle_control_if.sv | 38 +++
 rtl/multi_cycle_ctrl_decode.sv | 74 +++++++
 rtl/multi_cycle_control.sv | 77 +++++++
 tb/tb_multi_cycle_control.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcode constants,
// state encodings, aluop / alu_src_b / pc_source select codes and the strobe bundle.
package multi_cycle_control_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_EXEC   = 4'h6,
        S_ALUWB  = 4'h7,
        S_BRANCH = 4'h8,
        S_ADDIEX = 4'h9,
        S_ADDIWB = 4'hA,
        S_JUMP   = 4'hB,
        S_RST    = 4'hF
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control <-> datapath bundle: opcode/zero/mem_ready in, strobes out.
// master = control FSM side, slave = datapath side.
interface multi_cycle_control_if;
    import multi_cycle_control_pkg::*;

    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_en;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         aluop;
    logic [1:0]         pc_source;
    logic               illegal;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write,
        output reg_dst, mem_to_reg, reg_write, alu_src_a,
        output alu_src_b, aluop, pc_source, illegal, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write,
        input  reg_dst, mem_to_reg, reg_write, alu_src_a,
        input  alu_src_b, aluop, pc_source, illegal, state_dbg
    );

endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational state -> strobe table. Inputs: state, mem_ready, zero.
// Output: ctrl bundle. Optional JUMP row under MULTI_CTRL_JUMP_EN.
module multi_cycle_ctrl_decode
    import multi_cycle_control_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // IR load and PC+4 only land when the fetch completes
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MULTI_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (state, next-state, illegal flag).
// Ports: clk, rst_n (async, active low), bus (master). Option: MULTI_CTRL_JUMP_EN.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multi_cycle_control_if.master bus
);

    state_t state;
    logic   illegal;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_RST:    state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:     state <= S_EXEC;
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
`ifdef MULTI_CTRL_JUMP_EN
                        OP_J:         state <= S_JUMP;
`endif
                        default: begin
                            illegal <= 1'b1;
                            state   <= S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (bus.opcode == OP_SW) state <= S_MEMWR;
                    else                     state <= S_MEMRD;
                end
                S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_ADDIEX: state <= S_ADDIWB;
                S_ADDIWB: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    multi_cycle_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .zero      (bus.zero),
        .ctrl      (ctrl)
    );

    assign bus.pc_en      = ctrl.pc_en;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.aluop      = ctrl.aluop;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.illegal    = illegal;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle state, strobe and illegal checks.
// Honours MULTI_CTRL_JUMP_EN for the j instruction case.
module tb_multi_cycle_control;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic exp_ill;

    multi_cycle_control_if bus ();

    multi_cycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,
    //  reg_write,alu_src_a,alu_src_b[1:0],aluop[1:0],pc_source[1:0]}
    function automatic logic [14:0] obs();
        return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.aluop, bus.pc_source};
    endfunction

    // Expected strobes for a state, written from the control table
    function automatic logic [14:0] expv(input logic [3:0] st,
                                         input logic mr,
                                         input logic z);
        case (st)
            4'h0: return {mr, 1'b0, 1'b1, 1'b0, mr, 3'b000,
                          1'b0, 2'b01, 2'b00, 2'b00};
            4'h1: return {9'b0, 2'b11, 2'b00, 2'b00};
            4'h2: return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            4'h3: return {1'b0, 1'b1, 1'b1, 12'b0};
            4'h4: return {6'b0, 1'b1, 1'b1, 7'b0};
            4'h5: return {1'b0, 1'b1, 1'b0, 1'b1, 11'b0};
            4'h6: return {8'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            4'h7: return {5'b0, 1'b1, 1'b0, 1'b1, 7'b0};
            4'h8: return {z, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            4'h9: return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            4'hA: return {7'b0, 1'b1, 7'b0};
            4'hB: return {1'b1, 12'b0, 2'b10};
            default: return 15'b0;
        endcase
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] st);
        check({tag, ".state"}, 32'(bus.state_dbg), 32'(st));
        check({tag, ".ctrl"}, 32'(obs()),
              32'(expv(st, bus.mem_ready, bus.zero)));
        check({tag, ".ill"}, 32'(bus.illegal), 32'(exp_ill));
    endtask

    task automatic step(input string tag, input logic [3:0] st);
        @(posedge clk);
        @(negedge clk);
        look(tag, st);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_ill   = 1'b0;
        rst_n     = 1'b0;
        bus.opcode    = 6'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        look("rst", 4'hF);
        rst_n = 1'b1;
        step("rel", 4'h0);

        // FETCH stall: no IR/PC load while memory is busy
        bus.mem_ready = 1'b0;
        #1 look("fstall", 4'h0);
        step("fhold", 4'h0);
        bus.mem_ready = 1'b1;
        #1 look("fgo", 4'h0);

        // R-type
        bus.opcode = 6'b000000;
        step("r.dec", 4'h1);
        step("r.exe", 4'h6);
        step("r.wb", 4'h7);
        step("r.fet", 4'h0);

        // lw with 3 wait cycles in MEMRD
        bus.opcode = 6'b100011;
        step("lw.dec", 4'h1);
        step("lw.adr", 4'h2);
        bus.mem_ready = 1'b0;
        step("lw.rd0", 4'h3);
        step("lw.rd1", 4'h3);
        step("lw.rd2", 4'h3);
        bus.mem_ready = 1'b1;
        #1 look("lw.rd3", 4'h3);
        step("lw.wb", 4'h4);
        step("lw.fet", 4'h0);

        // beq taken / not taken
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        step("beq1.dec", 4'h1);
        step("beq1.br", 4'h8);
        check("beq1.pc_en", 32'(bus.pc_en), 32'd1);
        step("beq1.fet", 4'h0);
        bus.zero = 1'b0;
        step("beq0.dec", 4'h1);
        step("beq0.br", 4'h8);
        check("beq0.pc_en", 32'(bus.pc_en), 32'd0);
        step("beq0.fet", 4'h0);

        // illegal opcode, then addi keeps the sticky flag
        bus.opcode = 6'b111111;
        step("ill.dec", 4'h1);
        exp_ill = 1'b1;
        step("ill.fet", 4'h0);
        bus.opcode = 6'b001000;
        step("addi.dec", 4'h1);
        step("addi.ex", 4'h9);
        step("addi.wb", 4'hA);
        step("addi.fet", 4'h0);

        // only reset clears illegal
        rst_n   = 1'b0;
        exp_ill = 1'b0;
        #1 look("clr", 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        step("clr.fet", 4'h0);

        // j
        bus.opcode = 6'b000010;
        step("j.dec", 4'h1);
`ifdef MULTI_CTRL_JUMP_EN
        step("j.jmp", 4'hB);
        step("j.fet", 4'h0);
`else
        exp_ill = 1'b1;
        step("j.fet", 4'h0);
`endif

        // sw with reset asserted during the memory wait
        bus.opcode = 6'b101011;
        step("sw.dec", 4'h1);
        step("sw.adr", 4'h2);
        bus.mem_ready = 1'b0;
        step("sw.wr0", 4'h5);
        step("sw.wr1", 4'h5);
        rst_n   = 1'b0;
        exp_ill = 1'b0;
        #1 look("sw.rst", 4'hF);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step("sw.fet", 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
